// File: rtl/sub_sample.sv
// Two-stage neighborhood mean: registered full-width sum, then an exact
// floor division by the constant neighborhood size.
module sub_sample #(
    parameter int NN_WIDTH          = 8,
    parameter int NEIGHBORHOOD_SIZE = 4,
    parameter int NH_VECTOR_WIDTH   = NN_WIDTH * NEIGHBORHOOD_SIZE,
    parameter int SUM_WIDTH         = NN_WIDTH + $clog2(NEIGHBORHOOD_SIZE)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NH_VECTOR_WIDTH-1:0] rect_in,
    output logic [NN_WIDTH-1:0]        rect_out
);

    localparam int  LOG2_N = $clog2(NEIGHBORHOOD_SIZE);
    localparam bit  IS_POW2 =
        (NEIGHBORHOOD_SIZE & (NEIGHBORHOOD_SIZE - 1)) == 0;

    logic [SUM_WIDTH-1:0] sum_d;
    logic [SUM_WIDTH-1:0] sum_q;
    logic [NN_WIDTH-1:0]  quo_d;

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NEIGHBORHOOD_SIZE; k++) begin
            sum_d = sum_d + SUM_WIDTH'(rect_in[k*NN_WIDTH +: NN_WIDTH]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    generate
        if (IS_POW2) begin : g_shift
            assign quo_d = NN_WIDTH'(sum_q >> LOG2_N);
        end else begin : g_div
            localparam logic [SUM_WIDTH:0] DIV =
                (SUM_WIDTH + 1)'(NEIGHBORHOOD_SIZE);
            logic [SUM_WIDTH:0]   rem;
            logic [SUM_WIDTH-1:0] quo_full;

            // Restoring division, one quotient bit per sum bit, MSB first
            always_comb begin
                rem      = '0;
                quo_full = '0;
                for (int i = SUM_WIDTH - 1; i >= 0; i--) begin
                    rem = {rem[SUM_WIDTH-1:0], sum_q[i]};
                    if (rem >= DIV) begin
                        rem         = rem - DIV;
                        quo_full[i] = 1'b1;
                    end
                end
            end

            assign quo_d = NN_WIDTH'(quo_full);
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rect_out <= '0;
        end else begin
            rect_out <= quo_d;
        end
    end

endmodule

// File: tb/tb_sub_sample.sv
// Directed and randomized checks of sub_sample for sizes 4 and 9.
module tb_sub_sample;

    logic        clock;
    logic        reset;
    logic [31:0] rect_in;
    logic [7:0]  rect_out;
    logic [71:0] rect9;
    logic [7:0]  out9;

    int checks = 0;
    int errors = 0;

    sub_sample #(.NN_WIDTH(8), .NEIGHBORHOOD_SIZE(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .rect_in  (rect_in),
        .rect_out (rect_out)
    );

    sub_sample #(.NN_WIDTH(8), .NEIGHBORHOOD_SIZE(9)) dut9 (
        .clock    (clock),
        .reset    (reset),
        .rect_in  (rect9),
        .rect_out (out9)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mean4(input logic [31:0] v);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(v[k*8 +: 8]);
        return 8'(s / 4);
    endfunction

    logic [31:0] v;
    logic [7:0]  p1;
    logic [7:0]  exp_out;

    initial begin
        reset   = 1'b0;
        rect_in = 32'hA5C3_7E11;
        rect9   = {9{8'h77}};

        // Held in reset with live inputs and a running clock
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_hold", rect_out, 8'd0);
            chk("reset_hold9", out9, 8'd0);
        end

        // First edge after release must still produce 0 (sum was cleared)
        reset   = 1'b1;
        rect_in = 32'h291E_140A;
        rect9   = '0;
        tick();
        chk("first_out", rect_out, 8'd0);
        tick();
        chk("trunc_101", rect_out, 8'd25);

        // Back-to-back, one result per cycle
        rect_in = 32'h0404_0404;
        tick();
        rect_in = 32'h0808_0808;
        tick();
        chk("b2b_4", rect_out, 8'd4);
        rect_in = 32'h0603_0201;
        tick();
        chk("b2b_8", rect_out, 8'd8);
        rect_in = 32'hFFFF_FFFF;
        tick();
        chk("b2b_3", rect_out, 8'd3);
        rect_in = 32'h0000_0000;
        tick();
        chk("all_255", rect_out, 8'd255);
        tick();
        chk("all_0", rect_out, 8'd0);

        // Size-9 divider
        rect9 = {9{8'hFF}};
        tick();
        rect9 = {8'd8, 64'd0};
        tick();
        chk("n9_all_255", out9, 8'd255);
        rect9 = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        tick();
        chk("n9_only_8", out9, 8'd0);
        rect9 = '0;
        tick();
        chk("n9_1_to_9", out9, 8'd5);
        tick();
        chk("n9_zero", out9, 8'd0);

        // Asynchronous reset between edges flushes in-flight data
        rect_in = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("pre_rst", rect_out, 8'd255);
        #2 reset = 1'b0;
        #1 chk("async_rst", rect_out, 8'd0);
        @(negedge clock);
        reset   = 1'b1;
        rect_in = 32'h1010_1010;
        tick();
        chk("post_rst_flush", rect_out, 8'd0);
        tick();
        chk("post_rst_16", rect_out, 8'd16);

        // Random stream with occasional reset pulses
        p1 = 8'd16;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(49) == 0) begin
                reset = 1'b0;
                #1 chk("rnd_rst_async", rect_out, 8'd0);
                p1 = 8'd0;
                @(negedge clock);
                chk("rnd_rst_hold", rect_out, 8'd0);
                reset = 1'b1;
            end
            v       = $urandom;
            rect_in = v;
            tick();
            exp_out = p1;
            p1      = mean4(v);
            chk("rnd", rect_out, exp_out);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_sample.md
SUB_SAMPLE -- requirements
Module: sub_sample

Interface
REQ-001 Parameter NN_WIDTH, default 8, bit width of one unsigned neighborhood element.
REQ-002 Parameter NEIGHBORHOOD_SIZE, default 4, number of elements averaged (legal range 2..64; need not be a power of two).
REQ-003 Derived NH_VECTOR_WIDTH = NN_WIDTH*NEIGHBORHOOD_SIZE; SUM_WIDTH = NN_WIDTH + clog2(NEIGHBORHOOD_SIZE).
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 rect_in  input  NH_VECTOR_WIDTH  packed neighborhood; element k occupies bits [k*NN_WIDTH +: NN_WIDTH]; element 0 is in the LSBs.
REQ-007 rect_out  output  NN_WIDTH  registered mean of the neighborhood.

Function
REQ-008 The block SHALL compute floor(sum of all NEIGHBORHOOD_SIZE elements / NEIGHBORHOOD_SIZE), with all elements treated as unsigned.
REQ-009 The sum SHALL be formed at SUM_WIDTH bits with no intermediate overflow or truncation.
REQ-010 Division SHALL be exact truncating integer division for any NEIGHBORHOOD_SIZE:
 - power of two: right shift by log2(NEIGHBORHOOD_SIZE);
 - otherwise: a constant-divisor circuit (reciprocal multiply plus correction, or restoring divider) that yields bit-exact floor results for every input.
REQ-011 The quotient SHALL always fit in NN_WIDTH bits; rect_out SHALL be its low NN_WIDTH bits.
REQ-012 Pipeline: stage 1 registers the full-width sum of the rect_in value sampled at rising edge N; stage 2 registers the quotient into rect_out.
REQ-013 Latency SHALL be exactly 2 rising edges: rect_in sampled at edge N appears on rect_out after edge N+1 and holds until edge N+2.
REQ-014 Throughput SHALL be one new neighborhood per clock. There is no handshake; every cycle's input is processed.
REQ-015 rect_out SHALL change only on rising clock edges or on reset assertion (registered output, no combinational path from rect_in).
REQ-016 There is no enable and no state machine; the datapath runs continuously while reset is deasserted.

Reset
REQ-017 While reset=0, the stage-1 sum register and rect_out SHALL be forced to 0 immediately, without waiting for a clock edge.
REQ-018 After reset deasserts, the first valid rect_out SHALL be the mean of the rect_in sampled at the first rising edge with reset=1, appearing one edge later.
REQ-019 Reset asserted mid-operation SHALL discard in-flight sums; no pre-reset data may appear on rect_out after release.

Verification (NN_WIDTH=8, NEIGHBORHOOD_SIZE=4 unless stated)
REQ-020 Hold reset=0 with a nonzero rect_in and clock running -> rect_out=0 throughout. Assert reset between edges -> rect_out drops to 0 before the next edge.
REQ-021 Elements {10,20,30,41} (element 0 = 10) -> sum 101; rect_out=25 exactly 2 edges later (truncation check).
REQ-022 All elements 255 -> rect_out=255 (no sum overflow). All elements 0 -> rect_out=0.
REQ-023 Back-to-back inputs {4,4,4,4}, {8,8,8,8}, {1,2,3,6} on consecutive edges -> rect_out 4, 8, 3 on consecutive cycles (full throughput, latency 2).
REQ-024 Random rect_in for 1000 cycles, including random mid-stream reset pulses -> rect_out matches a floor-mean reference model delayed 2 cycles, and is 0 during and immediately after reset.
REQ-025 NEIGHBORHOOD_SIZE=9, NN_WIDTH=8: elements all 255 -> 255; elements {0,...,0,8} -> 0; elements 1..9 -> 5.
